// File: rtl/fwd_pkg.sv
// Shared definitions for the EX-stage forwarding / load-use hazard unit:
// forwarding-select encodings, load-use FSM states and the capture entry layout.
package fwd_pkg;

    localparam logic [1:0] FWD_IDEX  = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;
    localparam logic [1:0] FWD_CAP   = 2'b11;

    // Field widths of a stored capture entry; module widths default to these.
    localparam int FWD_REG_AW = 4;
    localparam int FWD_DATA_W = 16;

    typedef enum logic [0:0] {
        LU_RUN  = 1'b0,
        LU_WAIT = 1'b1
    } lu_state_e;

    typedef struct packed {
        logic                  valid;
        logic [FWD_REG_AW-1:0] rd;
        logic [FWD_DATA_W-1:0] data;
    } cap_entry_t;

    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        logic [31:0] result;
        if (value == 32'hFFFF_FFFF) begin
            result = value;
        end else begin
            result = value + 32'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/fwd_cap_buf.sv
// Writeback capture buffer: keeps MEM/WB results forwardable while EX is held,
// with in-place overwrite of a matching register and oldest-entry replacement.
module fwd_cap_buf
    import fwd_pkg::*;
#(
    parameter int REG_AW    = FWD_REG_AW,
    parameter int DATA_W    = FWD_DATA_W,
    parameter int NUM_SRC   = 2,
    parameter int CAP_DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push_en,
    input  logic [REG_AW-1:0]         push_rd,
    input  logic [DATA_W-1:0]         push_data,
    input  logic                      inval,
    input  logic [NUM_SRC*REG_AW-1:0] lookup_src,
    output logic [NUM_SRC-1:0]        hit,
    output logic [NUM_SRC*DATA_W-1:0] hit_data
);

    localparam int PTR_W = (CAP_DEPTH > 1) ? $clog2(CAP_DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(CAP_DEPTH - 1);

    cap_entry_t             entry_r [CAP_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_r;
    logic [CAP_DEPTH-1:0]   same_rd_s;
    logic                   same_any_s;
    cap_entry_t             new_entry_s;

    // Detect an existing entry for the incoming register and build the new entry.
    always_comb begin
        same_rd_s = {CAP_DEPTH{1'b0}};
        for (int e = 0; e < CAP_DEPTH; e++) begin
            same_rd_s[e] = entry_r[e].valid && (entry_r[e].rd == FWD_REG_AW'(push_rd));
        end
        same_any_s        = |same_rd_s;
        new_entry_s.valid = 1'b1;
        new_entry_s.rd    = FWD_REG_AW'(push_rd);
        new_entry_s.data  = FWD_DATA_W'(push_data);
    end

    // Entry storage; the buffer is cleared as a whole, so it always fills in
    // pointer order and wr_ptr_r marks either the next free slot or the oldest.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int e = 0; e < CAP_DEPTH; e++) begin
                entry_r[e] <= '0;
            end
            wr_ptr_r <= {PTR_W{1'b0}};
        end else if (inval) begin
            for (int e = 0; e < CAP_DEPTH; e++) begin
                entry_r[e].valid <= 1'b0;
            end
            wr_ptr_r <= {PTR_W{1'b0}};
        end else if (push_en) begin
            if (same_any_s) begin
                for (int e = 0; e < CAP_DEPTH; e++) begin
                    if (same_rd_s[e]) begin
                        entry_r[e] <= new_entry_s;
                    end
                end
            end else begin
                entry_r[wr_ptr_r] <= new_entry_s;
                wr_ptr_r <= (wr_ptr_r == PTR_LAST) ? {PTR_W{1'b0}} : (wr_ptr_r + PTR_W'(1));
            end
        end
    end

    // Per-source lookup; overwrite-in-place keeps register numbers unique, so
    // the single valid match is also the newest one and an OR-merge suffices.
    always_comb begin
        logic [REG_AW-1:0] src_v;
        logic              match_v;
        hit      = {NUM_SRC{1'b0}};
        hit_data = {(NUM_SRC*DATA_W){1'b0}};
        src_v    = {REG_AW{1'b0}};
        match_v  = 1'b0;
        for (int s = 0; s < NUM_SRC; s++) begin
            src_v = lookup_src[s*REG_AW +: REG_AW];
            for (int e = 0; e < CAP_DEPTH; e++) begin
                match_v = entry_r[e].valid && (entry_r[e].rd == FWD_REG_AW'(src_v))
                          && (src_v != {REG_AW{1'b0}});
                hit[s]  = hit[s] | match_v;
                hit_data[s*DATA_W +: DATA_W] = hit_data[s*DATA_W +: DATA_W]
                                               | ({DATA_W{match_v}} & DATA_W'(entry_r[e].data));
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// EX-stage operand forwarding with load-use stall FSM and writeback capture buffer.
// Optional FWD_PERF_CNT_EN adds saturating performance counters (ports tied to 0 otherwise).
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int DATA_W    = FWD_DATA_W,
    parameter int REG_AW    = FWD_REG_AW,
    parameter int NUM_SRC   = 2,
    parameter int CAP_DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_SRC*REG_AW-1:0] idex_src,
    input  logic [NUM_SRC*DATA_W-1:0] idex_op,
    input  logic [REG_AW-1:0]         exmem_rd,
    input  logic                      exmem_regwrite,
    input  logic                      exmem_memread,
    input  logic [DATA_W-1:0]         exmem_result,
    input  logic [REG_AW-1:0]         memwb_rd,
    input  logic                      memwb_regwrite,
    input  logic [DATA_W-1:0]         memwb_result,
    input  logic                      pipe_hold,
    output logic [NUM_SRC*DATA_W-1:0] op_out,
    output logic [NUM_SRC*2-1:0]      fwd_sel,
    output logic                      lu_stall,
    output logic [31:0]               cnt_exmem,
    output logic [31:0]               cnt_memwb,
    output logic [31:0]               cnt_stall
);

    logic [NUM_SRC-1:0]        cap_hit_s;
    logic [NUM_SRC*DATA_W-1:0] cap_data_s;
    logic [NUM_SRC-1:0]        ld_match_s;
    logic                      cap_push_s;
    logic                      cap_inval_s;
    logic                      lu_hazard_s;
    lu_state_e                 state_r;
    lu_state_e                 state_nxt_s;

    // Capture only while held; the first unheld cycle ends with a full clear,
    // which also wins over a coincident writeback.
    assign cap_push_s  = pipe_hold & memwb_regwrite & (memwb_rd != {REG_AW{1'b0}});
    assign cap_inval_s = ~pipe_hold;

    fwd_cap_buf #(
        .REG_AW    (REG_AW),
        .DATA_W    (DATA_W),
        .NUM_SRC   (NUM_SRC),
        .CAP_DEPTH (CAP_DEPTH)
    ) u_cap_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_en    (cap_push_s),
        .push_rd    (memwb_rd),
        .push_data  (memwb_result),
        .inval      (cap_inval_s),
        .lookup_src (idex_src),
        .hit        (cap_hit_s),
        .hit_data   (cap_data_s)
    );

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        logic [REG_AW-1:0] src_s;
        logic [1:0]        sel_s;
        logic [DATA_W-1:0] op_s;

        assign src_s         = idex_src[i*REG_AW +: REG_AW];
        assign ld_match_s[i] = (src_s == exmem_rd);

        // Priority select: EX/MEM (non-load), then MEM/WB, then capture buffer.
        always_comb begin
            sel_s = FWD_IDEX;
            if (src_s == {REG_AW{1'b0}}) begin
                sel_s = FWD_IDEX;
            end else if (exmem_regwrite && !exmem_memread && (exmem_rd == src_s)) begin
                sel_s = FWD_EXMEM;
            end else if (memwb_regwrite && (memwb_rd == src_s)) begin
                sel_s = FWD_MEMWB;
            end else if (cap_hit_s[i]) begin
                sel_s = FWD_CAP;
            end else begin
                sel_s = FWD_IDEX;
            end
        end

        // Operand data mux driven by the selection.
        always_comb begin
            op_s = idex_op[i*DATA_W +: DATA_W];
            case (sel_s)
                FWD_EXMEM: op_s = exmem_result;
                FWD_MEMWB: op_s = memwb_result;
                FWD_CAP:   op_s = cap_data_s[i*DATA_W +: DATA_W];
                FWD_IDEX:  op_s = idex_op[i*DATA_W +: DATA_W];
                default:   op_s = idex_op[i*DATA_W +: DATA_W];
            endcase
        end

        assign fwd_sel[i*2 +: 2]       = sel_s;
        assign op_out[i*DATA_W +: DATA_W] = op_s;
    end

    assign lu_hazard_s = exmem_regwrite & exmem_memread
                         & (exmem_rd != {REG_AW{1'b0}}) & (|ld_match_s);

    // Load-use FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= LU_RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Load-use FSM next state: one stall cycle, then the load sits in MEM/WB.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            LU_RUN: begin
                if (lu_hazard_s) begin
                    state_nxt_s = LU_WAIT;
                end else begin
                    state_nxt_s = LU_RUN;
                end
            end
            LU_WAIT: state_nxt_s = LU_RUN;
            default: state_nxt_s = LU_RUN;
        endcase
    end

    // Load-use FSM output.
    always_comb begin
        lu_stall = 1'b0;
        case (state_r)
            LU_RUN:  lu_stall = lu_hazard_s;
            LU_WAIT: lu_stall = 1'b0;
            default: lu_stall = 1'b0;
        endcase
    end

`ifdef FWD_PERF_CNT_EN
    logic [31:0] cnt_exmem_r;
    logic [31:0] cnt_memwb_r;
    logic [31:0] cnt_stall_r;
    logic        any_exmem_s;
    logic        any_memwb_s;

    // Per-cycle "any operand" flags for the counters.
    always_comb begin
        any_exmem_s = 1'b0;
        any_memwb_s = 1'b0;
        for (int s = 0; s < NUM_SRC; s++) begin
            any_exmem_s = any_exmem_s | (fwd_sel[s*2 +: 2] == FWD_EXMEM);
            any_memwb_s = any_memwb_s | (fwd_sel[s*2 +: 2] == FWD_MEMWB)
                                      | (fwd_sel[s*2 +: 2] == FWD_CAP);
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_exmem_r <= 32'd0;
            cnt_memwb_r <= 32'd0;
            cnt_stall_r <= 32'd0;
        end else begin
            cnt_exmem_r <= any_exmem_s ? sat_inc32(cnt_exmem_r) : cnt_exmem_r;
            cnt_memwb_r <= any_memwb_s ? sat_inc32(cnt_memwb_r) : cnt_memwb_r;
            cnt_stall_r <= lu_stall    ? sat_inc32(cnt_stall_r) : cnt_stall_r;
        end
    end

    assign cnt_exmem = cnt_exmem_r;
    assign cnt_memwb = cnt_memwb_r;
    assign cnt_stall = cnt_stall_r;
`else
    assign cnt_exmem = 32'd0;
    assign cnt_memwb = 32'd0;
    assign cnt_stall = 32'd0;
`endif

endmodule
